// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one UART transmitter between NREQ requesters,
// feeding each granted message LSB byte first over a start/busy handshake.
module uart_tx_scheduler #(
  parameter int NREQ        = 2,
  parameter int ACK_TIMEOUT = 400000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*64-1:0]   msg,
  input  logic [NREQ*4-1:0]    len,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [NREQ-1:0]      err,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic                 active
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: tx_start is a level held until the synchronised busy is seen high;
  // the byte is complete once synchronised busy returns low. tx_data never moves
  // while tx_start or synchronised busy is high.
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_ACK, S_WAIT_DONE, S_FINISH, S_ABORT
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     win_q, win_d;
  logic [63:0]       sreg_q, sreg_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       tmo_q, tmo_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [NREQ-1:0]   err_q, err_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              busy_s1_q, busy_s2_q;

  logic              arb_found;
  logic [PW-1:0]     arb_idx;
  int                arb_pos;
  logic [NREQ-1:0]   win_oh;
  logic [63:0]       msg_sel;
  logic [3:0]        len_sel;
  logic [3:0]        len_clip;

  // Search starts one past the last winner, so every requester gets a turn.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_pos   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      arb_pos = (int'(ptr_q) + k) % NREQ;
      if (!arb_found && req[arb_pos[PW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = arb_pos[PW-1:0];
      end
    end
  end

  always_comb begin
    win_oh         = '0;
    win_oh[win_q]  = 1'b1;
  end

  assign msg_sel  = msg[64*int'(win_q) +: 64];
  assign len_sel  = len[4*int'(win_q) +: 4];
  assign len_clip = (len_sel > 4'd8) ? 4'd8 : len_sel;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    sreg_d     = sreg_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    err_d      = '0;
    tx_data_d  = tx_data_q;
    tx_start_d = tx_start_q;
    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          win_d   = arb_idx;
          ptr_d   = arb_idx;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        sreg_d = msg_sel;
        cnt_d  = len_clip;
        gnt_d  = win_oh;
        if (len_clip == 4'd0) begin
          state_d = S_FINISH;
        end else begin
          tx_data_d = msg_sel[7:0];
          state_d   = S_START;
        end
      end
      S_START: begin
        tx_start_d = 1'b1;
        tmo_d      = '0;
        state_d    = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (busy_s2_q) begin
          tx_start_d = 1'b0;
          state_d    = S_WAIT_DONE;
        end else if (tmo_q >= 32'(ACK_TIMEOUT - 1)) begin
          tx_start_d = 1'b0;
          state_d    = S_ABORT;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!busy_s2_q) begin
          sreg_d = sreg_q >> 8;
          cnt_d  = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = S_FINISH;
          end else begin
            tx_data_d = sreg_q[15:8];
            state_d   = S_START;
          end
        end
      end
      S_FINISH: begin
        done_d  = gnt_q;
        gnt_d   = '0;
        state_d = S_IDLE;
      end
      S_ABORT: begin
        err_d   = gnt_q;
        gnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= PW'(NREQ - 1);
      win_q      <= '0;
      sreg_q     <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      busy_s1_q  <= 1'b0;
      busy_s2_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      sreg_q     <= sreg_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_s1_q  <= tx_busy;
      busy_s2_q  <= busy_s1_q;
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign err      = err_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign active   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: table of single-requester messages plus hand-written
// sequences for arbitration order, ack timeout and reset mid-message.
module tb_uart_tx_scheduler;

  logic         clk;
  logic         rst_n;
  logic [1:0]   req;
  logic [127:0] msg;
  logic [7:0]   len;
  logic [1:0]   gnt;
  logic [1:0]   done;
  logic [1:0]   err;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         tx_busy;
  logic         active;
  logic         busy_en;

  uart_tx_scheduler #(.NREQ(2), .ACK_TIMEOUT(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .msg      (msg),
    .len      (len),
    .gnt      (gnt),
    .done     (done),
    .err      (err),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .active   (active)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // transmitter model: accepts a byte on tx_start, raises busy two cycles later for six cycles
  logic [7:0] got_q[$];
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (busy_en && tx_start && rst_n) begin
        got_q.push_back(tx_data);
        repeat (2) @(negedge clk);
        tx_busy = 1'b1;
        repeat (6) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  // monitor: cumulative counters, read by the test as deltas
  int         done_cnt[2];
  int         err_cnt[2];
  int         start_cycles, gnt_cycles, gnt_gap, oh_viol, stab_viol;
  int         gnt_order[$];
  logic [1:0] gnt_prev;
  logic       start_prev;
  logic [7:0] data_prev;
  initial begin
    done_cnt = '{0, 0};
    err_cnt  = '{0, 0};
    start_cycles = 0; gnt_cycles = 0; gnt_gap = 0; oh_viol = 0; stab_viol = 0;
    gnt_prev = '0; start_prev = 1'b0; data_prev = '0;
  end
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (done[i]) done_cnt[i]++;
      if (err[i])  err_cnt[i]++;
    end
    if (gnt != 2'b00 && gnt != gnt_prev) gnt_order.push_back(gnt[1] ? 1 : 0);
    if ($countones(gnt) > 1 || $countones(done) > 1 || $countones(err) > 1 ||
        (done != 2'b00 && err != 2'b00)) oh_viol++;
    if (tx_start) start_cycles++;
    if (gnt != 2'b00) gnt_cycles++;
    if (tx_start && gnt == 2'b00) gnt_gap++;
    if (start_prev && tx_start && tx_data != data_prev) stab_viol++;
    gnt_prev   = gnt;
    start_prev = tx_start;
    data_prev  = tx_data;
  end

  // scoreboard
  logic [7:0] exp_q[$];
  int checks, errors;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  typedef struct {
    int          idx;
    logic [3:0]  len;
    logic [63:0] msg;
    int          exp_n;
    logic [63:0] exp_seq;
  } vec_t;
  vec_t vecs[6];

  int bd0, bd1, be0, be1, bs, bgc, bgg, bgot, bord, n;

  task automatic snap();
    bd0 = done_cnt[0]; bd1 = done_cnt[1]; be0 = err_cnt[0]; be1 = err_cnt[1];
    bs = start_cycles; bgc = gnt_cycles; bgg = gnt_gap;
    bgot = got_q.size(); bord = gnt_order.size();
  endtask

  function automatic int done_delta();
    return (done_cnt[0] - bd0) + (done_cnt[1] - bd1);
  endfunction

  function automatic int err_delta();
    return (err_cnt[0] - be0) + (err_cnt[1] - be1);
  endfunction

  task automatic compare_bytes(input string name);
    check({name, "_nbytes"}, 64'(got_q.size() - bgot), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++)
      if (bgot + k < got_q.size()) check({name, "_byte"}, 64'(got_q[bgot + k]), 64'(exp_q[k]));
  endtask

  task automatic wait_gnt(input string name);
    n = 0;
    while (gnt == 2'b00 && n < 40) begin step(); n++; end
    if (gnt == 2'b00) check({name, "_gnt_timeout"}, 64'(n), 64'd0);
  endtask

  task automatic wait_end(input string name);
    n = 0;
    while ((done | err) == 2'b00 && n < 2000) begin step(); n++; end
    if ((done | err) == 2'b00) check({name, "_end_timeout"}, 64'(n), 64'd0);
  endtask

  logic [1:0] exp_oh;

  initial begin
    checks = 0; errors = 0;
    busy_en = 1'b1;
    rst_n = 1'b0; req = '0; msg = '0; len = '0;

    vecs[0] = '{0, 4'd3,  64'hDEAD_BEEF_0056_3412, 3, 64'h0000_0000_0056_3412};
    vecs[1] = '{1, 4'd2,  64'h0000_0000_AABB_CCDD, 2, 64'h0000_0000_0000_CCDD};
    vecs[2] = '{1, 4'd0,  64'h1122_3344_5566_7788, 0, 64'h0};
    vecs[3] = '{0, 4'd8,  64'h8877_6655_4433_2211, 8, 64'h8877_6655_4433_2211};
    vecs[4] = '{1, 4'd15, 64'hF0E0_D0C0_B0A0_9080, 8, 64'hF0E0_D0C0_B0A0_9080};
    vecs[5] = '{0, 4'd1,  64'hFFFF_FFFF_FFFF_FF5A, 1, 64'h0000_0000_0000_005A};

    // reset values
    step();
    check("rst_gnt", 64'(gnt), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_err", 64'(err), 64'h0);
    check("rst_tx_data", 64'(tx_data), 64'h00);
    check("rst_tx_start", 64'(tx_start), 64'h0);
    check("rst_active", 64'(active), 64'h0);
    rst_n = 1'b1;
    repeat (2) step();
    check("idle_active", 64'(active), 64'h0);

    // table-driven single-requester messages; req dropped one cycle after grant
    for (int i = 0; i < 6; i++) begin
      snap();
      exp_q.delete();
      for (int k = 0; k < vecs[i].exp_n; k++) exp_q.push_back(vecs[i].exp_seq[8*k +: 8]);
      exp_oh = (vecs[i].idx == 1) ? 2'b10 : 2'b01;
      msg[64*vecs[i].idx +: 64] = vecs[i].msg;
      len[4*vecs[i].idx +: 4]   = vecs[i].len;
      req[vecs[i].idx]          = 1'b1;
      wait_gnt("vec");
      check("vec_gnt", 64'(gnt), 64'(exp_oh));
      step();
      req = '0;
      wait_end("vec");
      check("vec_done_pulse", 64'(done), 64'(exp_oh));
      repeat (3) step();
      check("vec_done_count", 64'(done_delta()), 64'd1);
      check("vec_err_count", 64'(err_delta()), 64'd0);
      compare_bytes("vec");
      check("vec_gnt_held", 64'(gnt_gap - bgg), 64'd0);
      check("vec_active_end", 64'(active), 64'h0);
      if (vecs[i].exp_n == 0) begin
        check("len0_gnt_cycles", 64'(gnt_cycles - bgc), 64'd1);
        check("len0_no_start", 64'(start_cycles - bs), 64'd0);
      end
    end

    // both requesting from reset: rotation gives 0, 1, 0
    rst_n = 1'b0;
    msg = {64'h0000_0000_0000_00B1, 64'h0000_0000_0000_00A0};
    len = {4'd1, 4'd1};
    req = 2'b11;
    repeat (2) step();
    snap();
    exp_q.delete();
    exp_q.push_back(8'hA0); exp_q.push_back(8'hB1); exp_q.push_back(8'hA0);
    rst_n = 1'b1;
    n = 0;
    while (gnt_order.size() - bord < 3 && n < 600) begin step(); n++; end
    req = '0;
    if (gnt_order.size() - bord < 3) check("rr_grant_timeout", 64'(n), 64'd0);
    n = 0;
    while (done_delta() < 3 && n < 300) begin step(); n++; end
    repeat (3) step();
    check("rr_done_count", 64'(done_delta()), 64'd3);
    if (gnt_order.size() - bord >= 3) begin
      check("rr_first", 64'(gnt_order[bord]), 64'd0);
      check("rr_second", 64'(gnt_order[bord + 1]), 64'd1);
      check("rr_third", 64'(gnt_order[bord + 2]), 64'd0);
    end
    compare_bytes("rr");

    // ack timeout: transmitter never raises busy
    busy_en = 1'b0;
    snap();
    msg[63:0] = 64'h0000_0000_0000_7766;
    len[3:0]  = 4'd2;
    req       = 2'b01;
    wait_gnt("tmo");
    step();
    req = '0;
    wait_end("tmo");
    check("tmo_err_pulse", 64'(err), 64'h1);
    repeat (3) step();
    check("tmo_start_cycles", 64'(start_cycles - bs), 64'd16);
    check("tmo_err_count", 64'(err_cnt[0] - be0), 64'd1);
    check("tmo_no_done", 64'(done_delta()), 64'd0);
    check("tmo_idle", 64'(active), 64'h0);
    check("tmo_tx_start_low", 64'(tx_start), 64'h0);
    busy_en = 1'b1;
    repeat (10) step();

    // reset during WAIT_DONE of byte 2 of 8
    snap();
    msg[63:0] = 64'h0807_0605_0403_0201;
    len[3:0]  = 4'd8;
    req       = 2'b01;
    n = 0;
    while (!(got_q.size() - bgot >= 2 && tx_busy) && n < 300) begin step(); n++; end
    check("rstmid_reached_byte2", 64'(got_q.size() - bgot), 64'd2);
    repeat (4) step();
    rst_n = 1'b0;
    req   = '0;
    #1;
    check("rstmid_gnt", 64'(gnt), 64'h0);
    check("rstmid_tx_start", 64'(tx_start), 64'h0);
    check("rstmid_tx_data", 64'(tx_data), 64'h00);
    check("rstmid_active", 64'(active), 64'h0);
    check("rstmid_done_err", 64'({done, err}), 64'h0);
    repeat (3) step();
    rst_n = 1'b1;
    snap();
    repeat (40) step();
    check("rstmid_no_start", 64'(start_cycles - bs), 64'd0);
    check("rstmid_no_done", 64'(done_delta() + err_delta()), 64'd0);

    check("onehot_violations", 64'(oh_viol), 64'd0);
    check("tx_data_stability", 64'(stab_viol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
